mcu_bus_write_regs: RTL and testbench
=====================================

MCU_BUS_WRITE_REGS -- requirements
Module: mcu_bus_write_regs

Interface
REQ-001 The block SHALL provide parameter ADDR_F1H, default 16'h0020, meaning the FREQ1 high-half write address.
REQ-002 The block SHALL provide parameter ADDR_F1L, default 16'h0021, meaning the FREQ1 low-half write address, which commits FREQ1.
REQ-003 The block SHALL provide parameter ADDR_F2H, default 16'h0022, meaning the FREQ2 high-half write address.
REQ-004 The block SHALL provide parameter ADDR_F2L, default 16'h0023, meaning the FREQ2 low-half write address, which commits FREQ2.
REQ-005 The block SHALL provide parameter ADDR_PH, default 16'h0024, meaning the 16-bit PHASE register address.
REQ-006 The block SHALL provide parameter ADDR_CTRL, default 16'h0025, meaning the 16-bit CTRL register address.
REQ-007 The block SHALL provide the following ports, one per line:
- CLK  in  1  system clock, the only clock.
- RST  in  1  synchronous, active-high reset.
- CS  in  1  MCU chip select, active-low, asynchronous to CLK.
- WR  in  1  MCU write strobe, active-low, asynchronous to CLK.
- ADDR  in  16  MCU address bus.
- DATA  in  16  MCU write data bus.
- FREQ1_WORD  out  32  committed FREQ1 value.
- FREQ2_WORD  out  32  committed FREQ2 value.
- PHASE_WORD  out  16  PHASE register.
- CTRL_WORD  out  16  CTRL register.
- FREQ1_UPD  out  1  one-cycle pulse on each FREQ1 commit.
- FREQ2_UPD  out  1  one-cycle pulse on each FREQ2 commit.
- WR_CNT  out  8  count of accepted writes to mapped addresses.

Function
REQ-010 CS, WR, ADDR and DATA SHALL pass through two CLK flip-flop stages each (s1, s2); a third WR stage (s3) SHALL hold the previous s2 value.
REQ-011 A write event SHALL be detected when WR_s2 = 1, WR_s3 = 0 and CS_s2 = 0, i.e. on the rising (trailing) edge of WR while the chip is selected.
REQ-012 On a write event, ADDR_s2 and DATA_s2 SHALL be decoded, and the targeted register SHALL update on the next CLK edge.
REQ-013 Latency: the register update and the UPD pulse SHALL be visible exactly 2 CLK cycles after the first CLK edge that samples WR = 1.
REQ-014 A write to F1H/F2H SHALL load a 16-bit shadow register only; the FREQx_WORD output SHALL NOT change.
REQ-015 A write to F1L/F2L SHALL load FREQx_WORD = {shadow_x, DATA_s2} atomically and assert FREQx_UPD for exactly 1 cycle.
REQ-016 A write to PH/CTRL SHALL load the full 16 bits directly; no UPD pulse is associated with these registers.
REQ-017 Repeated H writes before an L write SHALL leave the shadow holding the last H value.
REQ-018 An L write without a prior H write SHALL commit the current shadow contents (0 after reset).
REQ-019 A write to an unmapped address SHALL change no register, produce no pulse, and SHALL NOT increment WR_CNT.
REQ-020 WR_CNT SHALL increment by 1 per mapped write (H writes included) and SHALL wrap from 255 to 0.
REQ-021 A WR rising edge with CS_s2 = 1 SHALL be ignored.
REQ-022 WR low and high times SHALL each be at least 2 CLK periods.
REQ-023 ADDR, DATA and CS SHALL be stable from at least 2 CLK periods before the WR rising edge until 1 CLK period after it.
REQ-024 Under the timing of REQ-022 and REQ-023, each MCU strobe SHALL produce exactly one write event.
REQ-025 Strobe timing outside REQ-022 and REQ-023 is outside the contract.

Reset
REQ-030 While RST = 1 at a CLK edge, FREQ1_WORD, FREQ2_WORD, PHASE_WORD, CTRL_WORD, both shadows and WR_CNT SHALL clear to 0, and FREQ1_UPD and FREQ2_UPD SHALL clear to 0.
REQ-031 While RST = 1, the WR and CS synchronizer stages SHALL reset to 1 (idle), so that no false write event occurs when reset releases.
REQ-032 A strobe in progress when RST is asserted SHALL be discarded.
REQ-033 A WR rising edge whose s2/s3 comparison straddles reset release SHALL NOT generate a write event.

Verification
REQ-040 Write H=0x1234 then L=0x5678 to ADDR_F1H/ADDR_F1L -> FREQ1_WORD = 0x12345678, FREQ1_UPD high for 1 cycle 2 cycles after WR rise, WR_CNT = 2.
REQ-041 Write F2H=0xAAAA, F2H=0xBBBB, then F2L=0x0001 -> FREQ2_WORD = 0xBBBB0001; FREQ2_WORD unchanged after the H writes; exactly one FREQ2_UPD pulse.
REQ-042 Write 0x00FF to ADDR 0x0030 (unmapped), and write 0x1111 to ADDR_PH with CS = 1 -> all outputs unchanged, WR_CNT unchanged.
REQ-043 Perform 256 writes to ADDR_CTRL with data equal to the index -> CTRL_WORD = 0x00FF, WR_CNT = 0 (wrapped).
REQ-044 Assert RST for 1 cycle while WR is low during an F1L write, then release before WR rises -> all outputs 0, no FREQ1_UPD pulse, WR_CNT = 0.
REQ-045 Write ADDR_PH=0x8000 with random CLK-to-strobe phase offsets over 100 iterations -> PHASE_WORD = 0x8000 every iteration, with a latency of 2 or 3 cycles from the WR pin edge.

Source files
------------

// File: rtl/mcu_bus_write_regs.sv
`timescale 1ns/1ps
// mcu_bus_write_regs
// Takes writes from an asynchronous MCU bus (CS/WR active low) into the CLK
// domain and decodes them into a small register file:
//   FREQ1/FREQ2 : 32-bit words written as high half (shadow) then low half,
//                 where the low-half write commits the full word atomically
//                 and pulses FREQx_UPD for one cycle.
//   PHASE/CTRL  : 16-bit registers loaded directly.
//   WR_CNT      : wrapping count of writes that hit a mapped address.
// Ports:
//   CLK, RST            system clock, synchronous active-high reset
//   CS, WR              MCU chip select / write strobe, active low, async
//   ADDR[15:0]          MCU address bus
//   DATA[15:0]          MCU write data
//   FREQ1_WORD[31:0]    committed FREQ1
//   FREQ2_WORD[31:0]    committed FREQ2
//   PHASE_WORD[15:0]    PHASE register
//   CTRL_WORD[15:0]     CTRL register
//   FREQ1_UPD/FREQ2_UPD one-cycle commit pulses
//   WR_CNT[7:0]         mapped-write counter
// Write latency: the register and pulse appear two CLK edges after the first
// edge that samples WR high at the end of a strobe.
module mcu_bus_write_regs #(
  parameter logic [15:0] ADDR_F1H  = 16'h0020,
  parameter logic [15:0] ADDR_F1L  = 16'h0021,
  parameter logic [15:0] ADDR_F2H  = 16'h0022,
  parameter logic [15:0] ADDR_F2L  = 16'h0023,
  parameter logic [15:0] ADDR_PH   = 16'h0024,
  parameter logic [15:0] ADDR_CTRL = 16'h0025
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CS,
  input  logic        WR,
  input  logic [15:0] ADDR,
  input  logic [15:0] DATA,
  output logic [31:0] FREQ1_WORD,
  output logic [31:0] FREQ2_WORD,
  output logic [15:0] PHASE_WORD,
  output logic [15:0] CTRL_WORD,
  output logic        FREQ1_UPD,
  output logic        FREQ2_UPD,
  output logic [7:0]  WR_CNT
);

  // Synchronizer stages
  logic        cs_s1_q,   cs_s1_d;
  logic        cs_s2_q,   cs_s2_d;
  logic        wr_s1_q,   wr_s1_d;
  logic        wr_s2_q,   wr_s2_d;
  logic        wr_s3_q,   wr_s3_d;
  logic [15:0] addr_s1_q, addr_s1_d;
  logic [15:0] addr_s2_q, addr_s2_d;
  logic [15:0] data_s1_q, data_s1_d;
  logic [15:0] data_s2_q, data_s2_d;

  // Post-reset qualification of the strobe edge detector
  logic [1:0]  settle_q,  settle_d;
  logic        armed_q,   armed_d;

  // Register file
  logic [15:0] f1_shadow_q, f1_shadow_d;
  logic [15:0] f2_shadow_q, f2_shadow_d;
  logic [31:0] freq1_q,     freq1_d;
  logic [31:0] freq2_q,     freq2_d;
  logic [15:0] phase_q,     phase_d;
  logic [15:0] ctrl_q,      ctrl_d;
  logic        f1_upd_q,    f1_upd_d;
  logic        f2_upd_q,    f2_upd_d;
  logic [7:0]  wr_cnt_q,    wr_cnt_d;

  logic        wr_evt;
  logic        hit;

  // Trailing (rising) WR edge while selected. armed_q blocks a strobe that
  // was already low when reset released: its rising edge would otherwise
  // look like a complete write.
  assign wr_evt = armed_q & wr_s2_q & ~wr_s3_q & ~cs_s2_q;

  always_comb begin
    cs_s1_d   = CS;
    cs_s2_d   = cs_s1_q;
    wr_s1_d   = WR;
    wr_s2_d   = wr_s1_q;
    wr_s3_d   = wr_s2_q;
    addr_s1_d = ADDR;
    addr_s2_d = addr_s1_q;
    data_s1_d = DATA;
    data_s2_d = data_s1_q;

    // wr_s2_q reflects the real pin only once two edges have passed since
    // reset. Arm only after a genuine idle-high WR has been seen there.
    settle_d = (settle_q == 2'd2) ? 2'd2 : settle_q + 2'd1;
    armed_d  = armed_q | ((settle_q == 2'd2) & wr_s2_q);

    f1_shadow_d = f1_shadow_q;
    f2_shadow_d = f2_shadow_q;
    freq1_d     = freq1_q;
    freq2_d     = freq2_q;
    phase_d     = phase_q;
    ctrl_d      = ctrl_q;
    f1_upd_d    = 1'b0;
    f2_upd_d    = 1'b0;
    wr_cnt_d    = wr_cnt_q;
    hit         = 1'b0;

    if (wr_evt) begin
      hit = 1'b1;
      if (addr_s2_q == ADDR_F1H) begin
        f1_shadow_d = data_s2_q;
      end else if (addr_s2_q == ADDR_F1L) begin
        freq1_d  = {f1_shadow_q, data_s2_q};
        f1_upd_d = 1'b1;
      end else if (addr_s2_q == ADDR_F2H) begin
        f2_shadow_d = data_s2_q;
      end else if (addr_s2_q == ADDR_F2L) begin
        freq2_d  = {f2_shadow_q, data_s2_q};
        f2_upd_d = 1'b1;
      end else if (addr_s2_q == ADDR_PH) begin
        phase_d = data_s2_q;
      end else if (addr_s2_q == ADDR_CTRL) begin
        ctrl_d = data_s2_q;
      end else begin
        hit = 1'b0;
      end
      if (hit) wr_cnt_d = wr_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      // WR/CS stages idle high so release cannot fake an edge
      cs_s1_q     <= 1'b1;
      cs_s2_q     <= 1'b1;
      wr_s1_q     <= 1'b1;
      wr_s2_q     <= 1'b1;
      wr_s3_q     <= 1'b1;
      addr_s1_q   <= '0;
      addr_s2_q   <= '0;
      data_s1_q   <= '0;
      data_s2_q   <= '0;
      settle_q    <= '0;
      armed_q     <= 1'b0;
      f1_shadow_q <= '0;
      f2_shadow_q <= '0;
      freq1_q     <= '0;
      freq2_q     <= '0;
      phase_q     <= '0;
      ctrl_q      <= '0;
      f1_upd_q    <= 1'b0;
      f2_upd_q    <= 1'b0;
      wr_cnt_q    <= '0;
    end else begin
      cs_s1_q     <= cs_s1_d;
      cs_s2_q     <= cs_s2_d;
      wr_s1_q     <= wr_s1_d;
      wr_s2_q     <= wr_s2_d;
      wr_s3_q     <= wr_s3_d;
      addr_s1_q   <= addr_s1_d;
      addr_s2_q   <= addr_s2_d;
      data_s1_q   <= data_s1_d;
      data_s2_q   <= data_s2_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
      f1_shadow_q <= f1_shadow_d;
      f2_shadow_q <= f2_shadow_d;
      freq1_q     <= freq1_d;
      freq2_q     <= freq2_d;
      phase_q     <= phase_d;
      ctrl_q      <= ctrl_d;
      f1_upd_q    <= f1_upd_d;
      f2_upd_q    <= f2_upd_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  assign FREQ1_WORD = freq1_q;
  assign FREQ2_WORD = freq2_q;
  assign PHASE_WORD = phase_q;
  assign CTRL_WORD  = ctrl_q;
  assign FREQ1_UPD  = f1_upd_q;
  assign FREQ2_UPD  = f2_upd_q;
  assign WR_CNT     = wr_cnt_q;

endmodule

// File: tb/tb_mcu_bus_write_regs.sv
`timescale 1ns/1ps
module tb_mcu_bus_write_regs;

  localparam logic [15:0] A_F1H  = 16'h0020;
  localparam logic [15:0] A_F1L  = 16'h0021;
  localparam logic [15:0] A_F2H  = 16'h0022;
  localparam logic [15:0] A_F2L  = 16'h0023;
  localparam logic [15:0] A_PH   = 16'h0024;
  localparam logic [15:0] A_CTRL = 16'h0025;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CS = 1'b1;
  logic        WR = 1'b1;
  logic [15:0] ADDR = '0;
  logic [15:0] DATA = '0;
  logic [31:0] FREQ1_WORD, FREQ2_WORD;
  logic [15:0] PHASE_WORD, CTRL_WORD;
  logic        FREQ1_UPD, FREQ2_UPD;
  logic [7:0]  WR_CNT;

  mcu_bus_write_regs dut (
    .CLK(CLK), .RST(RST), .CS(CS), .WR(WR), .ADDR(ADDR), .DATA(DATA),
    .FREQ1_WORD(FREQ1_WORD), .FREQ2_WORD(FREQ2_WORD),
    .PHASE_WORD(PHASE_WORD), .CTRL_WORD(CTRL_WORD),
    .FREQ1_UPD(FREQ1_UPD), .FREQ2_UPD(FREQ2_UPD), .WR_CNT(WR_CNT)
  );

  always #5 CLK = ~CLK;

  // Count cycles each UPD is high; a stretched pulse shows up as extra counts.
  int f1_pulses = 0;
  int f2_pulses = 0;
  always @(negedge CLK) begin
    if (FREQ1_UPD) f1_pulses++;
    if (FREQ2_UPD) f2_pulses++;
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK); RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  // One complete MCU write strobe meeting the setup/hold/width contract.
  task automatic mcu_wr(input logic [15:0] a, input logic [15:0] d, input logic cs);
    @(negedge CLK); ADDR = a; DATA = d; CS = cs; WR = 1'b1;
    repeat (2) @(negedge CLK); WR = 1'b0;
    repeat (3) @(negedge CLK); WR = 1'b1;
    repeat (3) @(negedge CLK); CS = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        cs;
    logic [31:0] f1;
    logic [31:0] f2;
    logic [15:0] ph;
    logic [15:0] ctrl;
    logic [7:0]  cnt;
    int          f1p;
    int          f2p;
  } vec_t;

  vec_t vt[10];

  initial begin
    int f1b, f2b;
    real t0, lat;
    int off;
    bit seen;

    // addr, data, cs | FREQ1, FREQ2, PHASE, CTRL, WR_CNT, F1 pulses, F2 pulses
    vt[0] = '{A_F1H,  16'h1234, 1'b0, 32'h0,        32'h0,        16'h0,    16'h0,    8'd1, 0, 0};
    vt[1] = '{A_F1L,  16'h5678, 1'b0, 32'h12345678, 32'h0,        16'h0,    16'h0,    8'd2, 1, 0};
    vt[2] = '{A_F2H,  16'hAAAA, 1'b0, 32'h12345678, 32'h0,        16'h0,    16'h0,    8'd3, 1, 0};
    vt[3] = '{A_F2H,  16'hBBBB, 1'b0, 32'h12345678, 32'h0,        16'h0,    16'h0,    8'd4, 1, 0};
    vt[4] = '{A_F2L,  16'h0001, 1'b0, 32'h12345678, 32'hBBBB0001, 16'h0,    16'h0,    8'd5, 1, 1};
    vt[5] = '{16'h0030, 16'h00FF, 1'b0, 32'h12345678, 32'hBBBB0001, 16'h0,  16'h0,    8'd5, 1, 1};
    vt[6] = '{A_PH,   16'h1111, 1'b1, 32'h12345678, 32'hBBBB0001, 16'h0,    16'h0,    8'd5, 1, 1};
    vt[7] = '{A_PH,   16'h8000, 1'b0, 32'h12345678, 32'hBBBB0001, 16'h8000, 16'h0,    8'd6, 1, 1};
    vt[8] = '{A_CTRL, 16'h5A5A, 1'b0, 32'h12345678, 32'hBBBB0001, 16'h8000, 16'h5A5A, 8'd7, 1, 1};
    vt[9] = '{A_F1L,  16'h9999, 1'b0, 32'h12349999, 32'hBBBB0001, 16'h8000, 16'h5A5A, 8'd8, 2, 1};

    do_reset();
    chk("rst_f1",   FREQ1_WORD, 32'h0);
    chk("rst_f2",   FREQ2_WORD, 32'h0);
    chk("rst_ph",   {16'h0, PHASE_WORD}, 32'h0);
    chk("rst_ctrl", {16'h0, CTRL_WORD}, 32'h0);
    chk("rst_cnt",  {24'h0, WR_CNT}, 32'h0);
    chk("rst_upd",  {30'h0, FREQ1_UPD, FREQ2_UPD}, 32'h0);

    f1b = f1_pulses; f2b = f2_pulses;
    for (int i = 0; i < 10; i++) begin
      mcu_wr(vt[i].addr, vt[i].data, vt[i].cs);
      chk($sformatf("v%0d_f1", i),   FREQ1_WORD, vt[i].f1);
      chk($sformatf("v%0d_f2", i),   FREQ2_WORD, vt[i].f2);
      chk($sformatf("v%0d_ph", i),   {16'h0, PHASE_WORD}, {16'h0, vt[i].ph});
      chk($sformatf("v%0d_ctrl", i), {16'h0, CTRL_WORD}, {16'h0, vt[i].ctrl});
      chk($sformatf("v%0d_cnt", i),  {24'h0, WR_CNT}, {24'h0, vt[i].cnt});
      chk($sformatf("v%0d_f1p", i),  f1_pulses - f1b, vt[i].f1p);
      chk($sformatf("v%0d_f2p", i),  f2_pulses - f2b, vt[i].f2p);
    end

    // Cycle-exact latency of an F1L commit (shadow still 0x1234).
    @(negedge CLK); ADDR = A_F1L; DATA = 16'h0F0F; CS = 1'b0;
    repeat (2) @(negedge CLK); WR = 1'b0;
    repeat (3) @(negedge CLK); WR = 1'b1;
    @(negedge CLK);
    chk("lat_p0_upd", {31'h0, FREQ1_UPD}, 32'h0);
    @(negedge CLK);
    chk("lat_p1_upd", {31'h0, FREQ1_UPD}, 32'h0);
    chk("lat_p1_f1",  FREQ1_WORD, 32'h12349999);
    @(negedge CLK);
    chk("lat_p2_upd", {31'h0, FREQ1_UPD}, 32'h1);
    chk("lat_p2_f1",  FREQ1_WORD, 32'h12340F0F);
    @(negedge CLK);
    chk("lat_p3_upd", {31'h0, FREQ1_UPD}, 32'h0);
    chk("lat_cnt",    {24'h0, WR_CNT}, 32'd9);
    CS = 1'b1;
    repeat (2) @(negedge CLK);

    // L write straight after reset commits the cleared shadow.
    do_reset();
    mcu_wr(A_F2L, 16'h4321, 1'b0);
    chk("l_only_f2", FREQ2_WORD, 32'h00004321);

    // 256 CTRL writes wrap the counter back to zero.
    do_reset();
    for (int i = 0; i < 256; i++) mcu_wr(A_CTRL, 16'(i), 1'b0);
    chk("wrap_ctrl", {16'h0, CTRL_WORD}, 32'h00FF);
    chk("wrap_cnt",  {24'h0, WR_CNT}, 32'h0);

    // Reset pulsed mid-strobe; the trailing WR edge must be discarded.
    mcu_wr(A_F1H, 16'h7777, 1'b0);
    mcu_wr(A_PH,  16'h2222, 1'b0);
    f1b = f1_pulses;
    @(negedge CLK); ADDR = A_F1L; DATA = 16'hABCD; CS = 1'b0;
    repeat (2) @(negedge CLK); WR = 1'b0;
    repeat (2) @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    repeat (3) @(negedge CLK); WR = 1'b1;
    repeat (5) @(negedge CLK); CS = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rstmid_f1",   FREQ1_WORD, 32'h0);
    chk("rstmid_ph",   {16'h0, PHASE_WORD}, 32'h0);
    chk("rstmid_ctrl", {16'h0, CTRL_WORD}, 32'h0);
    chk("rstmid_cnt",  {24'h0, WR_CNT}, 32'h0);
    chk("rstmid_f1p",  f1_pulses - f1b, 32'h0);
    mcu_wr(A_F1L, 16'hABCD, 1'b0);
    chk("rstmid_next_f1",  FREQ1_WORD, 32'h0000ABCD);
    chk("rstmid_next_cnt", {24'h0, WR_CNT}, 32'h1);

    // Random strobe phase relative to CLK.
    for (int it = 0; it < 100; it++) begin
      mcu_wr(A_PH, 16'h0000, 1'b0);
      @(negedge CLK); ADDR = A_PH; DATA = 16'h8000; CS = 1'b0; WR = 1'b0;
      repeat (3) @(negedge CLK);
      @(posedge CLK);
      off = int'($urandom_range(1, 9));
      #(off);
      WR = 1'b1;
      t0 = $realtime;
      seen = 1'b0;
      lat = 0.0;
      for (int c = 0; c < 8 && !seen; c++) begin
        @(posedge CLK);
        #1;
        if (PHASE_WORD == 16'h8000) begin
          seen = 1'b1;
          lat = $realtime - 1.0 - t0;
        end
      end
      chk($sformatf("rnd%0d_ph", it), {16'h0, PHASE_WORD}, 32'h8000);
      checks++;
      if (!(seen && lat >= 20.0 && lat <= 30.0)) begin
        errs++;
        $display("FAIL rnd%0d_lat: got %0.1f ns expected 20..30 ns", it, lat);
      end
      repeat (2) @(negedge CLK); CS = 1'b1;
      repeat (2) @(negedge CLK);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
